fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Single-clock, parametrised synchronous FIFO for buffering data between producer and consumer blocks inside one clock domain, such as the register-file or UART TX paths. It generalises the asynchronous FIFO to any width and power-of-two depth. It adds an exact fill-level output, programmable almost-full and almost-empty thresholds, registered read data with a valid strobe, and optional sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_SIZE, 3, address bits; depth = 2**ADDR_SIZE (default 8)
- AFULL_TH, 6, ALMOST_FULL asserted when COUNT >= AFULL_TH; legal range 1..depth
- AEMPTY_TH, 2, ALMOST_EMPTY asserted when COUNT <= AEMPTY_TH; legal range 0..depth-1

Ports:
- CLK  in  1  single clock; all logic on its rising edge
- RST  in  1  reset, asynchronous and active-high
- WR_EN  in  1  write request
- WR_DATA  in  DATA_WIDTH  write word
- RD_EN  in  1  read request
- RD_DATA  out  DATA_WIDTH  registered read word
- RD_VALID  out  1  RD_DATA holds a newly popped word this cycle
- FULL  out  1  COUNT == depth
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  threshold flag
- ALMOST_EMPTY  out  1  threshold flag
- COUNT  out  ADDR_SIZE+1  number of stored words
- ERR_CLR  in  1  clears sticky error flags (FIFO_ERR_STICKY_EN only)
- OVERFLOW  out  1  sticky: a write was rejected
- UNDERFLOW  out  1  sticky: a read was rejected

## Operation
- Write and read pointers are ADDR_SIZE+1 bits wide. The MSB is the wrap bit and the low bits address memory.
- Write accepted (wr_acc) = WR_EN & (~FULL | rd_acc). A write is therefore allowed while full only when a read is accepted in the same cycle.
- Read accepted (rd_acc) = RD_EN & ~EMPTY. There is no write-through: a read while empty is rejected even if WR_EN is high.
- An accepted write stores WR_DATA at wptr[ADDR_SIZE-1:0], then wptr increments modulo 2**(ADDR_SIZE+1).
- An accepted read loads RD_DATA from rptr[ADDR_SIZE-1:0], asserts RD_VALID for one cycle, then rptr increments.
- COUNT changes by +1 for a write alone, -1 for a read alone, and 0 for both or neither. It never exceeds depth and never goes below 0.
- FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are registered and computed from the next-state COUNT. They are therefore valid in the same cycle as COUNT.
- RD_DATA holds its last value when no read is accepted.
- No other state machine: the block is pointer/counter datapath only.

## Timing
- Reset (async assert, sync deassert handled upstream) gives:
  - 0 on RD_DATA, RD_VALID, COUNT, FULL, ALMOST_FULL, OVERFLOW and UNDERFLOW
  - 1 on EMPTY and ALMOST_EMPTY
  - pointers set to 0; memory contents are not reset
- Read latency is 1 cycle: RD_EN sampled high at edge N gives RD_DATA/RD_VALID valid after edge N.
- Write-to-read latency is 1 cycle: a word written at edge N clears EMPTY after N and is readable at edge N+1.
- Full boundary: a write-only at depth-1 sets FULL after the edge. With simultaneous read and write at full, FULL stays 1 and both are accepted.
- Empty boundary: a read-only at COUNT 1 sets EMPTY after the edge.
- Wrap-around: pointers roll over freely. FULL is detected when the low bits are equal and the MSBs differ; this agrees with COUNT.
- Reset mid-operation discards all contents immediately. RD_VALID drops asynchronously.

## Configuration
- FIFO_ERR_STICKY_EN defined:
  - OVERFLOW sets on WR_EN & ~wr_acc.
  - UNDERFLOW sets on RD_EN & ~rd_acc.
  - Both stay set until ERR_CLR is high at an edge or until RST.
  - A set event coinciding with ERR_CLR wins, so the flag stays 1.
- FIFO_ERR_STICKY_EN undefined: OVERFLOW and UNDERFLOW are tied to 0, ERR_CLR is ignored, and no flops are inferred.
- Rejected accesses never corrupt pointers, with or without the macro.

## Structure
- fifo_sync_pkg holds:
  - depth computation (1 << ADDR_SIZE)
  - a pointer-width constant helper
  - parameter legality checks on the thresholds
- One sub-module, fifo_sync_mem: a dual-port register array with a synchronous write and registered read-enable output. It is instantiated once.
- Pointer/count/flag logic lives in the top.

## Test plan
- Reset, then idle: EMPTY=1, ALMOST_EMPTY=1, COUNT=0, RD_VALID=0, FULL=0.
- Write 0x01..0x08 on consecutive cycles (depth 8):
  - COUNT goes 1..8
  - ALMOST_EMPTY falls after the 3rd write
  - ALMOST_FULL rises after the 6th write
  - FULL rises after the 8th write
- At full, write 0xAA with RD_EN=0: the write is rejected, COUNT stays 8, and OVERFLOW=1 (macro on). Then read 8 times: RD_DATA is 0x01..0x08, each with RD_VALID, and EMPTY=1 after the last read.
- At full, simultaneous write 0x55 and read: RD_DATA=0x01, COUNT stays 8, and 0x55 later emerges as the 8th word.
- On empty, simultaneous WR 0x33 and RD: the read is rejected (RD_VALID=0, UNDERFLOW=1) and COUNT=1. Next-cycle read returns 0x33. ERR_CLR then clears both flags.
- 100 random-length bursts crossing the pointer wrap several times: scoreboard order is exact and COUNT always equals writes minus reads. Assert RST mid-burst: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and parameter checks for the parametrised synchronous FIFO.
package fifo_sync_pkg;

    function automatic int fifoDepth(input int addrSize);
        return 1 << addrSize;
    endfunction

    // One extra pointer bit distinguishes full from empty when the address bits match.
    function automatic int ptrWidth(input int addrSize);
        return addrSize + 1;
    endfunction

    function automatic bit thresholdsLegal(input int addrSize, input int afullTh, input int aemptyTh);
        return (afullTh >= 1) && (afullTh <= fifoDepth(addrSize)) &&
               (aemptyTh >= 0) && (aemptyTh <= fifoDepth(addrSize) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Dual-port register array: synchronous write, registered read data with a valid strobe.
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wrEn_i,
    input  logic [ADDR_SIZE-1:0]  wrAddr_i,
    input  logic [DATA_WIDTH-1:0] wrData_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_SIZE-1:0]  rdAddr_i,
    output logic [DATA_WIDTH-1:0] rdData_o,
    output logic                  rdValid_o
);

    localparam int DEPTH = fifoDepth(ADDR_SIZE);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;
    logic                  rdValid_q;

    // Storage is deliberately left unreset so it maps onto plain register or RAM cells.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= rdEn_i;
            if (rdEn_i) begin
                rdData_q <= mem_q[rdAddr_i];
            end
        end
    end

    assign rdData_o  = rdData_q;
    assign rdValid_o = rdValid_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill level, threshold flags and registered read data.
// Define FIFO_ERR_STICKY_EN to enable the sticky OVERFLOW/UNDERFLOW flags cleared by ERR_CLR.
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 3,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_SIZE:0]    COUNT,
    input  logic                  ERR_CLR,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int PTR_W = ptrWidth(ADDR_SIZE);
    localparam int DEPTH = fifoDepth(ADDR_SIZE);
    localparam logic [PTR_W-1:0] DEPTH_C    = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C    = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_C   = PTR_W'(AEMPTY_TH);
    localparam logic [PTR_W-1:0] PTR_STEP_C = PTR_W'(1);

    if (!thresholdsLegal(ADDR_SIZE, AFULL_TH, AEMPTY_TH)) begin : g_badThresholds
        $error("fifo_sync_param: AFULL_TH or AEMPTY_TH outside the legal range");
    end

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, empty_q, almostFull_q, almostEmpty_q;
    logic             wrAcc, rdAcc;

    // No write-through: an empty FIFO rejects reads even when a write arrives alongside.
    assign rdAcc = RD_EN & ~empty_q;
    assign wrAcc = WR_EN & (~full_q | rdAcc);

    // Occupancy is the pointer difference; the wrap bit keeps full distinct from empty.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + PTR_STEP_C;
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + PTR_STEP_C;
        end
        count_d = wrPtr_d - rdPtr_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= (count_d == DEPTH_C);
            empty_q       <= (count_d == '0);
            almostFull_q  <= (count_d >= AFULL_C);
            almostEmpty_q <= (count_d <= AEMPTY_C);
        end
    end

    fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE)
    ) u_mem (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wrEn_i    (wrAcc),
        .wrAddr_i  (wrPtr_q[ADDR_SIZE-1:0]),
        .wrData_i  (WR_DATA),
        .rdEn_i    (rdAcc),
        .rdAddr_i  (rdPtr_q[ADDR_SIZE-1:0]),
        .rdData_o  (RD_DATA),
        .rdValid_o (RD_VALID)
    );

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = almostFull_q;
    assign ALMOST_EMPTY = almostEmpty_q;
    assign COUNT        = count_q;

`ifdef FIFO_ERR_STICKY_EN
    logic overflow_q, underflow_q;

    // A rejection in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (WR_EN & ~wrAcc) begin
                overflow_q <= 1'b1;
            end else if (ERR_CLR) begin
                overflow_q <= 1'b0;
            end
            if (RD_EN & ~rdAcc) begin
                underflow_q <= 1'b1;
            end else if (ERR_CLR) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`else
    logic unusedErrClr;
    assign unusedErrClr = ERR_CLR;
    assign OVERFLOW     = 1'b0;
    assign UNDERFLOW    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed boundary cases plus randomized bursts
// checked by a queue-based reference model and a scoreboard monitor.
module tb_fifo_sync_param;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_SIZE  = 3;
    localparam int DEPTH      = 8;
    localparam int AFULL_TH   = 6;
    localparam int AEMPTY_TH  = 2;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  WR_EN = 1'b0;
    logic [DATA_WIDTH-1:0] WR_DATA = '0;
    logic                  RD_EN = 1'b0;
    logic                  ERR_CLR = 1'b0;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [ADDR_SIZE:0]    COUNT;
    logic                  OVERFLOW, UNDERFLOW;

    int checkCount = 0;
    int passCount  = 0;

    logic [DATA_WIDTH-1:0] modelQ[$];
    logic [DATA_WIDTH-1:0] expQ[$];
    bit mValid, mOvf, mUnf, mRdAcc, mWrAcc;

    fifo_sync_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .AFULL_TH   (AFULL_TH),
        .AEMPTY_TH  (AEMPTY_TH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_EN        (WR_EN),
        .WR_DATA      (WR_DATA),
        .RD_EN        (RD_EN),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .ERR_CLR      (ERR_CLR),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkModelState(input string tag);
        int n;
        n = modelQ.size();
        checkOutput({tag, ".count"}, 32'(COUNT), n);
        checkOutput({tag, ".full"}, 32'(FULL), 32'(n == DEPTH));
        checkOutput({tag, ".empty"}, 32'(EMPTY), 32'(n == 0));
        checkOutput({tag, ".afull"}, 32'(ALMOST_FULL), 32'(n >= AFULL_TH));
        checkOutput({tag, ".aempty"}, 32'(ALMOST_EMPTY), 32'(n <= AEMPTY_TH));
        checkOutput({tag, ".ovf"}, 32'(OVERFLOW), 32'(mOvf));
        checkOutput({tag, ".unf"}, 32'(UNDERFLOW), 32'(mUnf));
    endtask

    // Reference model: a plain queue of stored words, updated on each clock edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            modelQ.delete();
            expQ.delete();
            mValid = 1'b0;
            mOvf   = 1'b0;
            mUnf   = 1'b0;
        end else begin
            mRdAcc = RD_EN && (modelQ.size() > 0);
            mWrAcc = WR_EN && ((modelQ.size() < DEPTH) || mRdAcc);
            mValid = mRdAcc;
            if (mRdAcc) expQ.push_back(modelQ.pop_front());
            if (mWrAcc) modelQ.push_back(WR_DATA);
            if (STICKY) begin
                if (ERR_CLR) begin
                    mOvf = 1'b0;
                    mUnf = 1'b0;
                end
                if (WR_EN && !mWrAcc) mOvf = 1'b1;
                if (RD_EN && !mRdAcc) mUnf = 1'b1;
            end
        end
    end

    // Scoreboard monitor: pops an expected word whenever the DUT presents RD_VALID.
    always @(negedge CLK) begin
        if (RD_VALID === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rdUnexpected", 32'(RD_VALID), 32'd0);
            end else begin
                checkOutput("rdData", 32'(RD_DATA), 32'(expQ.pop_front()));
            end
        end
        checkOutput("rdValid", 32'(RD_VALID), 32'(mValid));
        checkModelState("cyc");
    end

    task automatic applyStimulus(input bit wr, input logic [DATA_WIDTH-1:0] d, input bit rd, input bit clr);
        @(negedge CLK);
        WR_EN   = wr;
        WR_DATA = d;
        RD_EN   = rd;
        ERR_CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic resetMidBurst();
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("preRst.valid", 32'(RD_VALID), 32'd1);
        @(negedge CLK);
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        ERR_CLR = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rstAsync.valid", 32'(RD_VALID), 32'd0);
        checkOutput("rstAsync.data", 32'(RD_DATA), 32'd0);
        checkOutput("rstAsync.count", 32'(COUNT), 32'd0);
        checkOutput("rstAsync.empty", 32'(EMPTY), 32'd1);
        checkOutput("rstAsync.aempty", 32'(ALMOST_EMPTY), 32'd1);
        checkOutput("rstAsync.full", 32'(FULL), 32'd0);
        checkOutput("rstAsync.ovf", 32'(OVERFLOW), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int len, pw, pr;
        logic [DATA_WIDTH-1:0] expData;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("rst.empty", 32'(EMPTY), 32'd1);
        checkOutput("rst.aempty", 32'(ALMOST_EMPTY), 32'd1);
        checkOutput("rst.count", 32'(COUNT), 32'd0);
        checkOutput("rst.valid", 32'(RD_VALID), 32'd0);
        checkOutput("rst.full", 32'(FULL), 32'd0);

        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill.count", 32'(COUNT), i);
            checkOutput("fill.aempty", 32'(ALMOST_EMPTY), 32'(i < 3));
            checkOutput("fill.afull", 32'(ALMOST_FULL), 32'(i >= 6));
            checkOutput("fill.full", 32'(FULL), 32'(i == 8));
        end

        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("ovf.count", 32'(COUNT), 32'd8);
        checkOutput("ovf.flag", 32'(OVERFLOW), 32'(STICKY));

        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain.valid", 32'(RD_VALID), 32'd1);
            checkOutput("drain.data", 32'(RD_DATA), i);
        end
        checkOutput("drain.empty", 32'(EMPTY), 32'd1);

        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("fullRw.data", 32'(RD_DATA), 32'h01);
        checkOutput("fullRw.count", 32'(COUNT), 32'd8);
        checkOutput("fullRw.full", 32'(FULL), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            expData = (i < DEPTH - 1) ? 8'(i + 2) : 8'h55;
            checkOutput("fullRw.drain", 32'(RD_DATA), 32'(expData));
        end

        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        checkOutput("emptyRw.valid", 32'(RD_VALID), 32'd0);
        checkOutput("emptyRw.unf", 32'(UNDERFLOW), 32'(STICKY));
        checkOutput("emptyRw.count", 32'(COUNT), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("emptyRw.data", 32'(RD_DATA), 32'h33);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr.ovf", 32'(OVERFLOW), 32'd0);
        checkOutput("clr.unf", 32'(UNDERFLOW), 32'd0);

        for (int b = 0; b < 100; b++) begin
            len = $urandom_range(1, 12);
            case ($urandom_range(0, 2))
                0:       begin pw = 85; pr = 20; end
                1:       begin pw = 20; pr = 85; end
                default: begin pw = 60; pr = 60; end
            endcase
            for (int k = 0; k < len; k++) begin
                applyStimulus($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                              $urandom_range(0, 19) == 0);
            end
            if (b == 60) resetMidBurst();
        end

        for (int k = 0; k < DEPTH + 2; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge CLK);
        #1;
        checkOutput("pendingReads", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
